// File: rtl/noise_pool_ctrl.sv
// Start/init sequencer, LFSR p/q/r/s address generator and sample FIFO for the Wallace noise core.
// Define NOISE_STATS_EN to add per-1024-sample window sums on stat_sum/stat_vld.
module noise_pool_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned INIT_CYCLES = 1026,
  parameter int unsigned LAT         = 6,
  parameter logic [39:0] SEED        = 40'h00_0000_0001
) (
  input  logic        CK,
  input  logic        RB,
  input  logic        en,
  output logic        gen_start,
  output logic [9:0]  p_addr,
  output logic [9:0]  q_addr,
  output logic [9:0]  r_addr,
  output logic [9:0]  s_addr,
  input  logic [23:0] c_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        busy,
  output logic [15:0] ovf_cnt
`ifdef NOISE_STATS_EN
  ,
  output logic signed [33:0] stat_sum,
  output logic               stat_vld
`endif
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntMax = (INIT_CYCLES > LAT) ? INIT_CYCLES : LAT;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StStart, StInit, StFill, StRun} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      grp_q, grp_d;
  logic [39:0]     lfsr_q, lfsr_d;
  logic [39:0]     addr_q, addr_d;
  logic [23:0]     mem_q [FIFO_DEPTH];
  logic [23:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     ovf_q, ovf_d;
  logic            active, push, pop, full, wr, drop;
  logic [9:0]      b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    grp_d   = grp_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) state_d = StStart;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StInit;
      end
      StInit: begin
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          state_d = StFill;
          cnt_d   = '0;
          grp_d   = '0;
        end
      end
      StFill: begin
        grp_d = grp_q + 2'd1;
        if (cnt_q == CW'(LAT - 1)) state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q;
        grp_d = grp_q + 2'd1;
        if (!en && grp_q == 2'd3) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // LFSR steps on the last cycle of a group; addresses pick up the new value one cycle later.
  assign active = (state_q == StFill) || (state_q == StRun);
  assign b      = lfsr_q[9:0];

  always_comb begin
    lfsr_d = lfsr_q;
    addr_d = addr_q;
    if (active && grp_q == 2'd3) begin
      lfsr_d = {lfsr_q[38:0], lfsr_q[39] ^ lfsr_q[37] ^ lfsr_q[20] ^ lfsr_q[18]};
    end
    if (active && grp_q == 2'd0) begin
      addr_d = {b, b ^ 10'h155, b ^ 10'h2AA, b ^ 10'h3FF};
    end
  end

  assign push = (state_q == StRun);
  assign full = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop  = m_valid && m_ready;
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (wr) begin
      mem_d[wptr_q] = c_in;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    if (wr && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wr && pop) count_d = count_q - (AW + 1)'(1);
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge CK) begin
    if (RB) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grp_q   <= '0;
      lfsr_q  <= SEED;
      addr_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge CK) begin
    mem_q <= mem_d;
  end

  assign gen_start = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign {p_addr, q_addr, r_addr, s_addr} = addr_q;
  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem_q[rptr_q] : '0;
  assign ovf_cnt   = ovf_q;

`ifdef NOISE_STATS_EN
  logic signed [33:0] acc_q, acc_d, sum_q, sum_d;
  logic        [9:0]  win_q, win_d;
  logic               vld_q, vld_d;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    win_d = win_q;
    vld_d = 1'b0;
    if (state_q == StStart) begin
      acc_d = '0;
      win_d = '0;
    end else if (push) begin
      acc_d = acc_q + $signed({{10{c_in[23]}}, c_in});
      win_d = win_q + 10'd1;
      if (win_q == 10'd1023) begin
        sum_d = acc_d;
        vld_d = 1'b1;
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RB) begin
      acc_q <= '0;
      sum_q <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
      win_q <= win_d;
      vld_q <= vld_d;
    end
  end

  assign stat_sum = sum_q;
  assign stat_vld = vld_q;
`endif

endmodule

// File: tb/tb_noise_pool_ctrl.sv
// Scoreboard bench for noise_pool_ctrl: timeline-based reference model pushes expected samples,
// a negedge monitor pops them on each handshake and checks all other outputs.
module tb_noise_pool_ctrl;

  localparam int INIT  = 1026;
  localparam int LAT   = 6;
  localparam int DEPTH = 16;
  localparam int RUN0  = INIT + LAT + 1;

  logic        CK = 1'b0;
  logic        RB, en, m_ready;
  logic [23:0] c_in;
  logic        gen_start, m_valid, busy;
  logic [9:0]  p_addr, q_addr, r_addr, s_addr;
  logic [23:0] m_data;
  logic [15:0] ovf_cnt;
`ifdef NOISE_STATS_EN
  logic signed [33:0] stat_sum;
  logic               stat_vld;
`endif

  always #5 CK = ~CK;

  noise_pool_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .INIT_CYCLES(INIT),
    .LAT        (LAT),
    .SEED       (40'h00_0000_0001)
  ) dut (
    .CK       (CK),
    .RB       (RB),
    .en       (en),
    .gen_start(gen_start),
    .p_addr   (p_addr),
    .q_addr   (q_addr),
    .r_addr   (r_addr),
    .s_addr   (s_addr),
    .c_in     (c_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .busy     (busy),
    .ovf_cnt  (ovf_cnt)
`ifdef NOISE_STATS_EN
    ,
    .stat_sum (stat_sum),
    .stat_vld (stat_vld)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [39:0] lfsr_next(input logic [39:0] v);
    return {v[38:0], v[39] ^ v[37] ^ v[20] ^ v[18]};
  endfunction

  // Reference model: m_t counts cycles since the start-pulse cycle (t=0).
  bit          m_idle = 1'b1;
  int          m_t    = 0;
  int          m_cnt  = 0;
  int          m_ovf  = 0;
  logic [23:0] exp_q[$];
  logic [39:0] m_lfsr = 40'h1;
  logic [9:0]  m_p = '0, m_q = '0, m_r = '0, m_s = '0;
  bit          m_have = 1'b0;
  longint      m_acc  = 0;
  int          m_win  = 0;
  logic signed [33:0] m_ssum = '0;
  logic        m_svld = 1'b0;

  always @(posedge CK) begin
    bit run, fr, push, pop;
    int grp;
    m_svld = 1'b0;
    if (RB) begin
      m_idle = 1'b1; m_t = 0; m_cnt = 0; m_ovf = 0; exp_q.delete();
      m_lfsr = 40'h1; m_p = '0; m_q = '0; m_r = '0; m_s = '0; m_have = 1'b0;
      m_acc = 0; m_win = 0; m_ssum = '0;
    end else begin
      fr   = !m_idle && (m_t >= INIT + 1);
      run  = !m_idle && (m_t >= RUN0);
      grp  = fr ? (m_t - INIT - 1) % 4 : 0;
      pop  = (m_cnt > 0) && m_ready;
      push = run;
      if (push) begin
        if (m_cnt < DEPTH || pop) begin
          exp_q.push_back(c_in);
          m_cnt++;
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
        m_acc += longint'($signed(c_in));
        m_win++;
        if (m_win == 1024) begin
          m_ssum = 34'(m_acc);
          m_svld = 1'b1;
          m_acc  = 0;
          m_win  = 0;
        end
      end
      if (pop) m_cnt--;
      if (!m_idle && m_t == 0) begin
        m_acc = 0;
        m_win = 0;
      end
      if (fr && grp == 0) begin
        m_p = m_lfsr[9:0];
        m_q = m_lfsr[9:0] ^ 10'h155;
        m_r = m_lfsr[9:0] ^ 10'h2AA;
        m_s = m_lfsr[9:0] ^ 10'h3FF;
        m_have = 1'b1;
      end
      if (fr && grp == 3) m_lfsr = lfsr_next(m_lfsr);
      if (m_idle) begin
        if (en) begin
          m_idle = 1'b0;
          m_t    = 0;
        end
      end else if (run && !en && grp == 3) begin
        m_idle = 1'b1;
      end else begin
        m_t++;
      end
    end
  end

  bit done = 1'b0;

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge CK) begin
    if (!done) begin
      check("gen_start", 64'(gen_start), 64'(!m_idle && m_t == 0));
      check("busy", 64'(busy), 64'(!m_idle));
      check("m_valid", 64'(m_valid), 64'(m_cnt > 0));
      check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      check("p_addr", 64'(p_addr), 64'(m_p));
      check("q_addr", 64'(q_addr), 64'(m_q));
      check("r_addr", 64'(r_addr), 64'(m_r));
      check("s_addr", 64'(s_addr), 64'(m_s));
      if (m_have) begin
        check("q^p", 64'(q_addr ^ p_addr), 64'h155);
        check("r^p", 64'(r_addr ^ p_addr), 64'h2AA);
        check("s^p", 64'(s_addr ^ p_addr), 64'h3FF);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'(m_valid), 64'(0));
        end else begin
          check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
`ifdef NOISE_STATS_EN
      check("stat_vld", 64'(stat_vld), 64'(m_svld));
      check("stat_sum", 64'(stat_sum), 64'(m_ssum));
`endif
    end
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  logic [23:0] ramp = '0;

  initial begin
    RB = 1'b1; en = 1'b0; m_ready = 1'b0; c_in = '0;
    repeat (3) step();
    check("reset_m_data", 64'(m_data), 64'(0));
    RB = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    // Ramp stream with a ready sink
    repeat (RUN0 + 60) begin
      c_in = ramp; ramp++;
      step();
    end
    // Back-pressure long enough to overflow
    m_ready = 1'b0;
    repeat (40) begin
      c_in = ramp; ramp++;
      step();
    end
    m_ready = 1'b1;
    repeat (40) begin
      c_in = ramp; ramp++;
      step();
    end
    // Random samples and random ready, long enough to close a stats window
    repeat (1100) begin
      c_in = 24'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    // Stop request: exits at a group boundary while the FIFO keeps draining
    en = 1'b0;
    repeat (30) begin
      c_in = 24'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    // Full restart, then reset mid-run with entries queued
    en = 1'b1;
    m_ready = 1'b1;
    repeat (RUN0 + 8) begin
      c_in = 24'($urandom);
      step();
    end
    m_ready = 1'b0;
    repeat (5) begin
      c_in = 24'($urandom);
      step();
    end
    RB = 1'b1;
    step();
    RB = 1'b0;
    repeat (RUN0 + 20) begin
      c_in = 24'($urandom);
      m_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    @(negedge CK);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_pool_ctrl.md
Name: noise_pool_ctrl

Overview:
- Initiator and consumer for the Wallace noise transform core.
- Issues the transform start pulse and waits out pool initialisation.
- Drives a distinct p/q/r/s address quadruple every transform group.
- Captures the unnormalized 24-bit sample stream `C` into a small FIFO, presented downstream with a valid/ready handshake; samples arriving to a full FIFO are dropped and counted.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries (power of 2, ≥4).
- INIT_CYCLES, 1026, cycles from start pulse until the core's pool init plus RAM write-back completes.
- LAT, 6, cycles from first post-init address quadruple to first valid `C`.
- SEED, 40'h00_0000_0001, LFSR reset value (must be nonzero).

Ports:
- CK  in  1  clock
- RB  in  1  reset, synchronous, active-high
- en  in  1  run request (level)
- gen_start  out  1  start pulse to transform core
- p_addr  out  10  pool address p
- q_addr  out  10  pool address q
- r_addr  out  10  pool address r
- s_addr  out  10  pool address s
- c_in  in  24  unnormalized sample from core (two's complement)
- m_valid  out  1  FIFO head valid
- m_ready  in  1  downstream accept
- m_data  out  24  FIFO head sample
- busy  out  1  FSM not IDLE
- ovf_cnt  out  16  dropped-sample count, saturating

Behaviour:
- Reset (RB=1 at posedge CK), all outputs:
  - gen_start=0, addresses=0, m_valid=0, m_data=0, busy=0, ovf_cnt=0.
  - FIFO emptied, LFSR=SEED, FSM=IDLE.
  - Reset mid-run aborts immediately with no drain.
- FSM:
  - IDLE: if en, go to START.
  - START: gen_start=1 for exactly one cycle; go to INIT with cycle counter cleared.
  - INIT: count to INIT_CYCLES-1, then go to FILL.
  - FILL: addresses advance; count LAT cycles, then go to RUN.
  - RUN: push c_in every cycle.
    - If en=0, go to IDLE at the next group boundary (grp==3).
    - The FIFO is not flushed; remaining entries still drain via the handshake.
  - en re-asserted in IDLE always restarts via START (full re-init).
- Address generation:
  - 40-bit Fibonacci LFSR, taps 40,38,21,19.
  - 2-bit group counter grp is cleared on FILL entry and increments each cycle in FILL/RUN.
  - LFSR advances when grp==3; addresses update from the new state on the following cycle, so each quadruple is held 4 cycles.
  - b = lfsr[9:0]; p=b, q=b^10'h155, r=b^10'h2AA, s=b^10'h3FF. The four addresses are always pairwise distinct.
  - Addresses hold their last value in IDLE/START/INIT.
- FIFO:
  - Push when FSM=RUN. Pop when m_valid && m_ready.
  - Simultaneous push+pop when full: both occur, no drop.
  - Push when full without pop: sample dropped; ovf_cnt increments, saturating at 16'hFFFF.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_data is the registered head, valid the same cycle as m_valid.
  - Ordering is strict FIFO; sample values are passed bit-exact.
- Latency: first push occurs INIT_CYCLES+LAT+1 cycles after gen_start. m_valid rises the cycle after that push.
- busy=1 in START/INIT/FILL/RUN.

Optional Feature:
- Macro: NOISE_STATS_EN.
- Enabled:
  - Adds outputs stat_sum (out, 34-bit, signed) and stat_vld (out, 1).
  - Pushed samples are sign-extended and accumulated over windows of 1024 pushes.
  - At each window end, stat_sum latches the window sum and stat_vld pulses 1 cycle; the accumulator then restarts.
  - Reset clears both; START clears the accumulator.
- Disabled: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then en=1 → gen_start high exactly at cycle 1 after en sampled; busy=1; no m_valid before cycle 1+1026+6+2.
- SEED=1, FILL entry → quadruples follow LFSR; each held 4 cycles; q^p=10'h155, s^p=10'h3FF for every quadruple.
- RUN with c_in ramp 0,1,2,… and m_ready=1 → m_data reproduces the ramp in order; ovf_cnt=0.
- RUN with m_ready=0 for 40 cycles, FIFO_DEPTH=16 → 16 entries retained (ramp 0..15), ovf_cnt=24; releasing m_ready drains 0..15, then new samples follow.
- RB asserted mid-RUN with 5 entries queued → next cycle m_valid=0, ovf_cnt=0, FSM IDLE; with en still 1, gen_start pulses one cycle later.
- NOISE_STATS_EN, c_in constant 24'hFFFFFE (−2) → stat_vld after 1024 pushes with stat_sum=−2048.
